// File: rtl/calc_pkg.sv
// Shared types and key codes for the calculator entry datapath.
package calc_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2
    } op_e;

    typedef enum logic [1:0] {
        ENTER_A = 2'd0,
        ENTER_B = 2'd1,
        CALC    = 2'd2,
        SHOW    = 2'd3
    } state_e;

    localparam logic [3:0] KEY_ADD = 4'hA;
    localparam logic [3:0] KEY_SUB = 4'hB;
    localparam logic [3:0] KEY_MUL = 4'hC;
    localparam logic [3:0] KEY_CLR = 4'hE;
    localparam logic [3:0] KEY_EQ  = 4'hF;

    function automatic logic is_digit(input logic [3:0] k);
        return k <= 4'd9;
    endfunction

    function automatic logic is_oper(input logic [3:0] k);
        return (k == KEY_ADD) || (k == KEY_SUB) || (k == KEY_MUL);
    endfunction

    function automatic op_e key_to_op(input logic [3:0] k);
        case (k)
            KEY_SUB: return OP_SUB;
            KEY_MUL: return OP_MUL;
            default: return OP_ADD;
        endcase
    endfunction

    // Largest operand representable with the given number of decimal digits.
    function automatic int unsigned max_operand(input int unsigned digits);
        int unsigned v;
        v = 1;
        for (int unsigned i = 0; i < digits; i++) v = v * 10;
        return v - 1;
    endfunction

endpackage

// File: rtl/calc_entry_fsm_seq_mult.sv
// Unsigned shift-add multiplier; done pulses OPW-1 cycles after the start cycle.
module seq_mult
    import calc_pkg::*;
#(
    parameter int unsigned OPW = 7
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic [OPW-1:0]     a,
    input  logic [OPW-1:0]     b,
    output logic               done,
    output logic [2*OPW-1:0]   product
);

    localparam int unsigned CW = $clog2(OPW + 1);

    logic [2*OPW-1:0] mcand;
    logic [OPW-1:0]   mplier;
    logic [CW-1:0]    cnt;
    logic             running;

    // Bit 0 of the multiplier is folded into the start cycle so the
    // remaining OPW-1 bits finish in time for the caller's fixed latency.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcand   <= '0;
            mplier  <= '0;
            cnt     <= '0;
            running <= 1'b0;
            done    <= 1'b0;
            product <= '0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                running <= 1'b0;
                cnt     <= '0;
            end else if (start) begin
                mcand   <= (2*OPW)'(a) << 1;
                mplier  <= b >> 1;
                product <= b[0] ? (2*OPW)'(a) : '0;
                cnt     <= CW'(OPW - 1);
                running <= 1'b1;
            end else if (running) begin
                product <= product + (mplier[0] ? mcand : '0);
                mcand   <= mcand << 1;
                mplier  <= mplier >> 1;
                cnt     <= cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    running <= 1'b0;
                    done    <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/calc_entry_fsm.sv
// Keypad entry FSM: builds two decimal operands, an operator and a result for display.
module calc_entry_fsm
    import calc_pkg::*;
#(
    parameter int unsigned MAX_DIGITS = 2,
    parameter int unsigned OPW        = 7,
    parameter int unsigned RESW       = 14
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            key_valid,
    input  logic [3:0]      key_code,
    output logic [OPW-1:0]  op_a,
    output logic [OPW-1:0]  op_b,
    output logic [RESW-1:0] disp_val,
    output logic            disp_neg,
    output logic [1:0]      state_o,
    output logic            busy,
    output logic            done,
    output logic            err
);

    localparam int unsigned CW     = $clog2(MAX_DIGITS + 1);
    localparam int unsigned OP_MAX = max_operand(MAX_DIGITS);

    state_e           state;
    op_e              op;
    logic [CW-1:0]    cnt_a;
    logic [CW-1:0]    cnt_b;
    logic [RESW-1:0]  result;
    logic             mult_start;
    logic             mult_done;
    logic [2*OPW-1:0] product;

    logic             key_clr;
    logic             key_dig;
    logic             key_op;
    logic             key_eq;
    logic [OPW-1:0]   next_a;
    logic [OPW-1:0]   next_b;
    logic [RESW-1:0]  calc_res;
    logic             calc_neg;
    logic             calc_fin;

    function automatic logic [OPW-1:0] dec_append(input logic [OPW-1:0] v, input logic [3:0] d);
        return OPW'((OPW+4)'(v) * (OPW+4)'(10) + (OPW+4)'(d));
    endfunction

    assign key_clr = key_valid && (key_code == KEY_CLR);
    assign key_dig = key_valid && is_digit(key_code);
    assign key_op  = key_valid && is_oper(key_code);
    assign key_eq  = key_valid && (key_code == KEY_EQ);
    assign next_a  = dec_append(op_a, key_code);
    assign next_b  = dec_append(op_b, key_code);
    assign state_o = state;

    always_comb begin
        calc_res = '0;
        calc_neg = 1'b0;
        calc_fin = 1'b1;
        case (op)
            OP_ADD: calc_res = RESW'(op_a) + RESW'(op_b);
            OP_SUB: begin
                if (op_a >= op_b) begin
                    calc_res = RESW'(op_a - op_b);
                end else begin
                    calc_res = RESW'(op_b - op_a);
                    calc_neg = 1'b1;
                end
            end
            OP_MUL: begin
                calc_res = RESW'(product);
                calc_fin = mult_done;
            end
            default: calc_res = '0;
        endcase
    end

    seq_mult #(.OPW(OPW)) u_mult (
        .clk     (clk),
        .reset   (reset),
        .start   (mult_start),
        .abort   (key_clr),
        .a       (op_a),
        .b       (op_b),
        .done    (mult_done),
        .product (product)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ENTER_A;
            op         <= OP_ADD;
            op_a       <= '0;
            op_b       <= '0;
            cnt_a      <= '0;
            cnt_b      <= '0;
            result     <= '0;
            disp_val   <= '0;
            disp_neg   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            mult_start <= 1'b0;
        end else begin
            done       <= 1'b0;
            err        <= 1'b0;
            mult_start <= 1'b0;
            if (key_clr) begin
                state    <= ENTER_A;
                op       <= OP_ADD;
                op_a     <= '0;
                op_b     <= '0;
                cnt_a    <= '0;
                cnt_b    <= '0;
                result   <= '0;
                disp_val <= '0;
                disp_neg <= 1'b0;
                busy     <= 1'b0;
            end else begin
                case (state)
                    ENTER_A: begin
                        if (key_dig && cnt_a < CW'(MAX_DIGITS)) begin
                            op_a     <= next_a;
                            cnt_a    <= cnt_a + CW'(1);
                            disp_val <= RESW'(next_a);
                        end else if (key_op) begin
                            op       <= key_to_op(key_code);
                            op_b     <= '0;
                            cnt_b    <= '0;
                            state    <= ENTER_B;
                            disp_val <= RESW'(op_a);
                        end
                    end
                    ENTER_B: begin
                        if (key_dig && cnt_b < CW'(MAX_DIGITS)) begin
                            op_b     <= next_b;
                            cnt_b    <= cnt_b + CW'(1);
                            disp_val <= RESW'(next_b);
                        end else if (key_op && cnt_b == '0) begin
                            op <= key_to_op(key_code);
                        end else if (key_eq) begin
                            state      <= CALC;
                            busy       <= 1'b1;
                            mult_start <= (op == OP_MUL);
                        end
                    end
                    CALC: begin
                        if (calc_fin) begin
                            result   <= calc_res;
                            disp_val <= calc_res;
                            disp_neg <= calc_neg;
                            state    <= SHOW;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                        end
                    end
                    SHOW: begin
                        if (key_dig) begin
                            op_a     <= OPW'(key_code);
                            cnt_a    <= CW'(1);
                            op_b     <= '0;
                            cnt_b    <= '0;
                            disp_neg <= 1'b0;
                            disp_val <= RESW'(key_code);
                            state    <= ENTER_A;
                        end else if (key_op) begin
                            // Only a non-negative result that fits an operand can seed a chain.
                            if (!disp_neg && result <= RESW'(OP_MAX)) begin
                                op_a     <= OPW'(result);
                                cnt_a    <= CW'(MAX_DIGITS);
                                op       <= key_to_op(key_code);
                                op_b     <= '0;
                                cnt_b    <= '0;
                                disp_val <= result;
                                state    <= ENTER_B;
                            end else begin
                                err <= 1'b1;
                            end
                        end else if (key_eq) begin
                            state      <= CALC;
                            busy       <= 1'b1;
                            disp_neg   <= 1'b0;
                            mult_start <= (op == OP_MUL);
                        end
                    end
                    default: state <= ENTER_A;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_calc_entry_fsm.sv
// Randomized scoreboard bench for calc_entry_fsm against an arithmetic reference model.
module tb_calc_entry_fsm;

    localparam int MAXD    = 2;
    localparam int OPW     = 7;
    localparam int RESW    = 14;
    localparam int MUL_LAT = OPW + 1;

    logic            clk;
    logic            reset;
    logic            key_valid;
    logic [3:0]      key_code;
    logic [OPW-1:0]  op_a;
    logic [OPW-1:0]  op_b;
    logic [RESW-1:0] disp_val;
    logic            disp_neg;
    logic [1:0]      state_o;
    logic            busy;
    logic            done;
    logic            err;

    calc_entry_fsm #(.MAX_DIGITS(MAXD), .OPW(OPW), .RESW(RESW)) dut (
        .clk       (clk),
        .reset     (reset),
        .key_valid (key_valid),
        .key_code  (key_code),
        .op_a      (op_a),
        .op_b      (op_b),
        .disp_val  (disp_val),
        .disp_neg  (disp_neg),
        .state_o   (state_o),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // kind 0 = calculation finished, kind 1 = rejected chain operator
    typedef struct {
        int kind;
        int val;
        int neg;
        int a;
        int b;
        int lat;
    } exp_t;

    exp_t sbq[$];
    int   vectors;
    int   miscompares;

    // Reference model: phase 0..3 = entering A, entering B, calculating, showing.
    int m_ph, m_a, m_b, m_ca, m_cb, m_rem, m_res, m_disp, m_neg, m_op;

    task automatic check(input string name, input int act, input int expv);
        vectors++;
        if (act != expv) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    function automatic bit is_op(input int k);
        return (k == 10) || (k == 11) || (k == 12);
    endfunction

    task automatic model_reset();
        m_ph = 0; m_a = 0; m_b = 0; m_ca = 0; m_cb = 0;
        m_rem = 0; m_res = 0; m_disp = 0; m_neg = 0; m_op = 10;
    endtask

    task automatic model_enter_calc();
        exp_t e;
        m_neg = 0;
        if (m_op == 10) m_res = m_a + m_b;
        else if (m_op == 11) begin
            if (m_a >= m_b) m_res = m_a - m_b;
            else begin m_res = m_b - m_a; m_neg = 1; end
        end else m_res = m_a * m_b;
        m_rem = (m_op == 12) ? MUL_LAT : 1;
        m_ph  = 2;
        e = '{kind: 0, val: m_res, neg: m_neg, a: m_a, b: m_b, lat: m_rem};
        sbq.push_back(e);
    endtask

    task automatic drop_pending();
        if (m_ph == 2 && sbq.size() > 0 && sbq[sbq.size()-1].kind == 0) sbq.pop_back();
    endtask

    task automatic model_edge(input bit v, input int k);
        exp_t e;
        if (v && k == 14) begin
            drop_pending();
            model_reset();
        end else if (m_ph == 2) begin
            m_rem--;
            if (m_rem == 0) begin m_ph = 3; m_disp = m_res; end
        end else if (v) begin
            case (m_ph)
                0: begin
                    if (k <= 9) begin
                        if (m_ca < MAXD) begin m_a = m_a * 10 + k; m_ca++; m_disp = m_a; end
                    end else if (is_op(k)) begin
                        m_op = k; m_b = 0; m_cb = 0; m_ph = 1; m_disp = m_a;
                    end
                end
                1: begin
                    if (k <= 9) begin
                        if (m_cb < MAXD) begin m_b = m_b * 10 + k; m_cb++; m_disp = m_b; end
                    end else if (is_op(k)) begin
                        if (m_cb == 0) m_op = k;
                    end else if (k == 15) model_enter_calc();
                end
                default: begin
                    if (k <= 9) begin
                        m_a = k; m_ca = 1; m_b = 0; m_cb = 0; m_neg = 0; m_ph = 0; m_disp = m_a;
                    end else if (is_op(k)) begin
                        if (m_neg == 0 && m_res <= 99) begin
                            m_a = m_res; m_ca = MAXD; m_op = k; m_b = 0; m_cb = 0;
                            m_ph = 1; m_disp = m_a;
                        end else begin
                            e = '{kind: 1, val: 0, neg: 0, a: 0, b: 0, lat: 0};
                            sbq.push_back(e);
                        end
                    end else if (k == 15) model_enter_calc();
                end
            endcase
        end
    endtask

    task automatic check_all();
        check("state_o", state_o, m_ph);
        check("op_a", op_a, m_a);
        check("op_b", op_b, m_b);
        check("disp_val", disp_val, m_disp);
        check("disp_neg", disp_neg, (m_ph == 3) ? m_neg : 0);
        check("busy", busy, (m_ph == 2) ? 1 : 0);
    endtask

    task automatic step(input bit v, input int k);
        key_valid = v;
        key_code  = 4'(k);
        @(posedge clk);
        model_edge(v, k);
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0);
    endtask

    task automatic keys(input string s);
        for (int i = 0; i < s.len(); i++) begin
            if (s[i] >= "0" && s[i] <= "9") step(1'b1, int'(s[i]) - int'("0"));
            else step(1'b1, int'(s[i]) - int'("A") + 10);
        end
    endtask

    // Monitor: pops an expectation whenever the DUT announces done or err.
    int   busy_cnt;
    exp_t mon_e;
    always @(negedge clk) begin
        if (reset) busy_cnt = 0;
        else begin
            if (done || err) begin
                if (sbq.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_event: got done=%0d err=%0d, expected none", done, err);
                end else begin
                    mon_e = sbq.pop_front();
                    check("event_kind", done ? 0 : 1, mon_e.kind);
                    check("event_state", state_o, 3);
                    if (done) begin
                        check("result_val", disp_val, mon_e.val);
                        check("result_neg", disp_neg, mon_e.neg);
                        check("result_op_a", op_a, mon_e.a);
                        check("result_op_b", op_b, mon_e.b);
                        check("calc_cycles", busy_cnt, mon_e.lat);
                    end
                end
            end
            busy_cnt = busy ? busy_cnt + 1 : 0;
        end
    end

    initial begin
        int r;
        int k;
        vectors     = 0;
        miscompares = 0;
        busy_cnt    = 0;
        key_valid   = 1'b0;
        key_code    = 4'h0;
        reset       = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        check("reset_done", done, 0);
        check("reset_err", err, 0);
        @(posedge clk);
        #3 reset = 1'b0;

        keys("42A17F");     idle(3);
        keys("E999C99F");   idle(10);
        keys("E3B12F");     idle(3);
        keys("A");          idle(2);
        keys("E5AB4F");     idle(3);
        keys("C3F");        idle(10);
        keys("F");          idle(10);
        keys("7AE");
        keys("FD");         idle(2);
        keys("12D3DA4DF");  idle(4);

        // Asynchronous reset in the middle of a multiply.
        keys("E6C7F");
        idle(3);
        reset = 1'b1;
        #1;
        drop_pending();
        model_reset();
        check_all();
        check("midcalc_done", done, 0);
        @(posedge clk);
        #3 reset = 1'b0;
        idle(12);

        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 99);
            if (r < 30) step(1'b0, $urandom_range(0, 15));
            else begin
                r = $urandom_range(0, 99);
                if (r < 55)      k = $urandom_range(0, 9);
                else if (r < 75) k = $urandom_range(10, 12);
                else if (r < 90) k = 15;
                else if (r < 93) k = 14;
                else             k = 13;
                step(1'b1, k);
            end
        end
        key_valid = 1'b0;
        idle(20);
        check("queue_drained", sbq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/calc_entry_fsm.md
Name: calc_entry_fsm

Overview:
Consumes decoded key strobes from the keypad matrix scanner and turns them into two decimal operands, an operator and a computed result for the display driver. Digits accumulate in decimal (×10 + d), up to MAX_DIGITS per operand. Supported operations are add, subtract and multiply; multiply runs on a sequential shift-add unit. Sits between the keypad scanner and the 7-segment/BCD display stage.

Parameters:
MAX_DIGITS, 2, maximum decimal digits per operand (operand max 99)
OPW, 7, operand width in bits (must hold 10^MAX_DIGITS − 1)
RESW, 14, result magnitude width (must hold 99×99 = 9801)

Ports:
clk  in  1  system clock; all logic on rising edge
reset  in  1  asynchronous, active-high; clears all state
key_valid  in  1  one-cycle strobe: key_code is valid this cycle
key_code  in  4  0–9 digit; A add; B sub; C mul; E clear; F equals; D reserved
op_a  out  OPW  first operand
op_b  out  OPW  second operand
disp_val  out  RESW  value the display shows
disp_neg  out  1  display value is negative (sub only)
state_o  out  2  current FSM state, for debug and LEDs
busy  out  1  high while in CALC
done  out  1  one-cycle pulse on entry to SHOW
err  out  1  one-cycle pulse on a rejected chain operator

Behaviour:
- Reset (async, any state): state=ENTER_A, op_a=op_b=0, digit counts=0, op=ADD, result=0, disp_neg=0; busy=done=err=0.
- States: ENTER_A(0), ENTER_B(1), CALC(2), SHOW(3). Only a key_valid cycle advances the FSM, except inside CALC.
- Clear (E) in any state, including mid-CALC: same effect as reset, one clock later. Any in-flight multiply is abandoned.
- Code D: always ignored.
- ENTER_A:
  - Digit with cnt_a<MAX_DIGITS: op_a ← op_a×10+d, cnt_a++. Digit with cnt_a=MAX_DIGITS: ignored.
  - Operator: op latched, op_b=0, cnt_b=0, go ENTER_B. Zero digits entered is legal (op_a=0).
  - Equals: ignored.
- ENTER_B:
  - Digits: same rules as ENTER_A, applied to op_b/cnt_b.
  - Operator with cnt_b=0: replaces the latched op. Operator with cnt_b>0: ignored.
  - Equals: go CALC, even with cnt_b=0 (op_b=0).
- CALC:
  - busy=1. Every key except clear is ignored.
  - ADD: result=op_a+op_b, 1 cycle in CALC.
  - SUB: if op_a≥op_b, result=op_a−op_b and neg=0; else result=op_b−op_a and neg=1. 1 cycle in CALC.
  - MUL: start pulse to seq_mult in the first CALC cycle. Result is taken on mult done, exactly OPW+1 cycles in CALC in total.
  - Then go SHOW with a done pulse in the same cycle the state becomes SHOW.
- SHOW:
  - Digit: op_a=d, cnt_a=1, op_b=0, neg=0, go ENTER_A.
  - Operator with neg=0 and result≤99: op_a=result, cnt_a=MAX_DIGITS, op latched, op_b=0, cnt_b=0, go ENTER_B.
  - Operator otherwise: err pulse, stay in SHOW.
  - Equals: re-run CALC with the current op_a/op_b (repeat).
- disp_val (registered, updated with state):
  - ENTER_A: op_a.
  - ENTER_B: op_a while cnt_b=0, else op_b.
  - CALC: holds its previous value.
  - SHOW: result.
- disp_neg: 1 only in SHOW after a negative SUB.
- Widths: op_a×10 is computed in OPW+4 bits before truncation; it cannot overflow given the digit limit.
- Simultaneous events: key_valid during a done cycle is still ignored, because the state is CALC on that edge.

Decomposition:
- Package calc_pkg holds:
  - op_e (ADD/SUB/MUL)
  - state_e encodings
  - key constants KEY_ADD=4'hA, KEY_SUB=4'hB, KEY_MUL=4'hC, KEY_CLR=4'hE, KEY_EQ=4'hF
- Sub-module seq_mult:
  - OPW×OPW unsigned shift-add multiplier, interface start/done/product[2·OPW−1:0].
  - Its own async active-high reset, plus an abort input driven by clear.

Test Plan:
- Reset mid-CALC during MUL → all outputs zero, state_o=0 on the next sample; no done pulse.
- Keys 4,2,A,1,7,F → op_a=42, op_b=17; done after 1 CALC cycle; disp_val=59, disp_neg=0.
- Keys 9,9,9,C,9,9,F → third 9 ignored, op_a=99; busy exactly 8 cycles; disp_val=9801.
- Keys 3,B,1,2,F → disp_val=9, disp_neg=1. Then A → err pulse, state_o stays 3.
- Keys 5,A,B,4,F → op replaced by SUB; disp_val=1. Then C,3,F → op_a=1, disp_val=3. Then F → disp_val=3 again (repeat).
- Keys 7,A,E → state_o=0, op_a=0. Then F → ignored. Key D anywhere → no state change.
